window_3x3_gen: RTL and testbench

//   Raster-to-neighbourhood front end for the 3x3 kernel filters (gaus_filter and peers).

---
 rtl/window_3x3_gen_if.sv | 26 ++
 rtl/window_3x3_gen.sv | 107 ++++++++++
 tb/tb_window_3x3_gen.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/window_3x3_gen_if.sv
// Pixel-stream in / 3x3 window out bundle for window_3x3_gen.
// The pixel producer is master; the window generator is slave.
interface window_3x3_gen_if #(
  parameter int DATA_IN_WIDTH = 8
);
  logic [DATA_IN_WIDTH-1:0] pix_in;
  logic                     pix_valid_in;
  logic                     sof_in;
  logic [DATA_IN_WIDTH-1:0] d00_out, d01_out, d02_out;
  logic [DATA_IN_WIDTH-1:0] d10_out, d11_out, d12_out;
  logic [DATA_IN_WIDTH-1:0] d20_out, d21_out, d22_out;
  logic                     win_valid_out;
  logic                     frame_done_out;

  modport master (
    output pix_in, pix_valid_in, sof_in,
    input  d00_out, d01_out, d02_out, d10_out, d11_out, d12_out,
           d20_out, d21_out, d22_out, win_valid_out, frame_done_out
  );

  modport slave (
    input  pix_in, pix_valid_in, sof_in,
    output d00_out, d01_out, d02_out, d10_out, d11_out, d12_out,
           d20_out, d21_out, d22_out, win_valid_out, frame_done_out
  );
endinterface

// File: rtl/window_3x3_gen.sv
// Raster pixel stream to registered 3x3 neighbourhood, using two line buffers
// and three 3-tap column shift registers; windows only for interior pixels.
module window_3x3_gen #(
  parameter int DATA_IN_WIDTH = 8,
  parameter int IMG_WIDTH     = 640,
  parameter int IMG_HEIGHT    = 480
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  window_3x3_gen_if.slave   bus
);
  localparam int DW = DATA_IN_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {WAIT_SOF, FILL, STREAM} state_t;

  state_t                     state;
  logic [CW-1:0]              col;
  logic [RW-1:0]              row;
  logic [DW-1:0]              lb1 [IMG_WIDTH];  // row r-1
  logic [DW-1:0]              lb2 [IMG_WIDTH];  // row r-2
  logic [2:0][2:0][DW-1:0]    sr;               // [row][tap], tap 2 newest
  logic [2:0][2:0][DW-1:0]    nxt;
  logic [2:0][2:0][DW-1:0]    win;
  logic [2:0][DW-1:0]         col_in;
  logic                       win_valid, frame_done;

  logic          accept, issue, col_last, row_last;
  logic [CW-1:0] pc;
  logic [RW-1:0] pr;

  // sof always restarts the raster at (0,0), whatever the current state
  assign accept   = bus.pix_valid_in & (bus.sof_in | (state != WAIT_SOF));
  assign pc       = bus.sof_in ? '0 : col;
  assign pr       = bus.sof_in ? '0 : row;
  assign col_last = (pc == COL_LAST);
  assign row_last = (pr == ROW_LAST);
  assign issue    = accept & (pr >= RW'(2)) & (pc >= CW'(2));

  assign col_in[0] = lb2[pc];
  assign col_in[1] = lb1[pc];
  assign col_in[2] = bus.pix_in;

  always_comb begin
    nxt = sr;
    for (int i = 0; i < 3; i++) begin
      nxt[i][0] = sr[i][1];
      nxt[i][1] = sr[i][2];
      nxt[i][2] = col_in[i];
    end
  end

  // Line-buffer RAM: no reset, FILL keeps stale contents out of any window
  always_ff @(posedge clk_in) begin
    if (accept) begin
      lb2[pc] <= lb1[pc];
      lb1[pc] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= WAIT_SOF;
      col        <= '0;
      row        <= '0;
      sr         <= '0;
      win        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= issue;
      frame_done <= 1'b0;
      if (issue) win <= nxt;
      if (accept) begin
        sr  <= nxt;
        col <= col_last ? '0 : pc + CW'(1);
        row <= col_last ? (row_last ? '0 : pr + RW'(1)) : pr;
        if (bus.sof_in) state <= FILL;
        else begin
          case (state)
            FILL:    if (col_last && pr == RW'(1)) state <= STREAM;
            STREAM:  if (col_last && row_last) begin
                       state      <= WAIT_SOF;
                       frame_done <= 1'b1;
                     end
            default: state <= state;
          endcase
        end
      end
    end
  end

  assign bus.d00_out        = win[0][0];
  assign bus.d01_out        = win[0][1];
  assign bus.d02_out        = win[0][2];
  assign bus.d10_out        = win[1][0];
  assign bus.d11_out        = win[1][1];
  assign bus.d12_out        = win[1][2];
  assign bus.d20_out        = win[2][0];
  assign bus.d21_out        = win[2][1];
  assign bus.d22_out        = win[2][2];
  assign bus.win_valid_out  = win_valid;
  assign bus.frame_done_out = frame_done;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on a 4x4 image: per-cycle reference model plus
// table of known windows for the directed frame scenarios.
module tb_window_3x3_gen;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
  typedef logic [9*DW-1:0] win_t;

  typedef struct {
    int   idx;  // position in the captured window sequence
    win_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_3x3_gen_if #(.DATA_IN_WIDTH(DW)) bus ();

  window_3x3_gen #(.DATA_IN_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .bus(bus)
  );

  int checks = 0, errors = 0;

  // reference model: frame image plus raster position, straight from the rules
  logic [DW-1:0] img [H][W];
  bit   m_active;
  int   m_r, m_c;
  win_t m_win;
  bit   m_wv, m_fd;

  win_t got_q[$];
  int   fd_cnt;

  function automatic win_t cur_win();
    return {bus.d00_out, bus.d01_out, bus.d02_out, bus.d10_out, bus.d11_out,
            bus.d12_out, bus.d20_out, bus.d21_out, bus.d22_out};
  endfunction

  function automatic win_t w9(int a, int b, int c, int d, int e, int f, int g, int h, int i);
    return {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e), DW'(f), DW'(g), DW'(h), DW'(i)};
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (bus.win_valid_out) got_q.push_back(cur_win());
    if (bus.frame_done_out) fd_cnt++;
  end

  task automatic chk(string name, win_t got, win_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_r = 0; m_c = 0; m_win = '0; m_wv = 0; m_fd = 0;
  endtask

  task automatic step(bit v, bit s, logic [DW-1:0] p);
    bus.pix_valid_in = v; bus.sof_in = s; bus.pix_in = p;
    m_wv = 0; m_fd = 0;
    if (v && (s || m_active)) begin
      if (s) begin m_r = 0; m_c = 0; m_active = 1; end
      img[m_r][m_c] = p;
      if (m_r >= 2 && m_c >= 2) begin
        m_wv = 1;
        m_win = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            m_win = (m_win << DW) | win_t'(img[m_r-2+i][m_c-2+j]);
      end
      if (m_r == H-1 && m_c == W-1) begin m_fd = 1; m_active = 0; end
      m_c++;
      if (m_c == W) begin m_c = 0; m_r = (m_r == H-1) ? 0 : m_r + 1; end
    end
    @(posedge clk); #1;
    chk("win_valid", win_t'(bus.win_valid_out), win_t'(m_wv));
    chk("frame_done", win_t'(bus.frame_done_out), win_t'(m_fd));
    chk("window", cur_win(), m_win);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, DW'($urandom));
  endtask

  task automatic frame(int base, bit gaps, int npix = W*H);
    for (int k = 0; k < npix; k++) begin
      while (gaps && $urandom_range(0, 2) == 0) step(0, 0, DW'($urandom));
      step(1, k == 0, DW'(base + k));
    end
  endtask

  task automatic clear_mon();
    got_q.delete(); fd_cnt = 0;
  endtask

  task automatic chk_table(string name, vec_t tbl[], int exp_n, int exp_fd);
    chk({name, "_count"}, win_t'(got_q.size()), win_t'(exp_n));
    chk({name, "_frame_done"}, win_t'(fd_cnt), win_t'(exp_fd));
    foreach (tbl[k])
      if (tbl[k].idx < got_q.size()) chk({name, "_win"}, got_q[tbl[k].idx], tbl[k].exp);
      else chk({name, "_win_missing"}, '0, tbl[k].exp);
  endtask

  vec_t t1[];
  vec_t t4[];

  initial begin
    t1 = new[4];
    t1[0] = '{0, w9(0, 1, 2, 4, 5, 6, 8, 9, 10)};
    t1[1] = '{1, w9(1, 2, 3, 5, 6, 7, 9, 10, 11)};
    t1[2] = '{2, w9(4, 5, 6, 8, 9, 10, 12, 13, 14)};
    t1[3] = '{3, w9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
    t4 = new[5];
    for (int k = 0; k < 4; k++) t4[k] = t1[k];
    t4[4] = '{4, w9(100, 101, 102, 104, 105, 106, 108, 109, 110)};

    bus.pix_valid_in = 0; bus.sof_in = 0; bus.pix_in = '0;
    model_reset();
    #1;
    chk("reset_window", cur_win(), '0);
    chk("reset_win_valid", win_t'(bus.win_valid_out), '0);
    chk("reset_frame_done", win_t'(bus.frame_done_out), '0);
    @(posedge clk); #1; rst_n = 1'b1;

    // T1 continuous frame
    clear_mon(); frame(0, 0); idle(2); chk_table("t1", t1, 4, 1);
    // T2 random valid gaps
    clear_mon(); frame(0, 1); idle(2); chk_table("t2", t1, 4, 1);
    // T3 pixels before any sof are dropped
    clear_mon();
    for (int k = 0; k < 6; k++) step(1, 0, DW'(200 + k));
    frame(0, 0); idle(2); chk_table("t3", t1, 4, 1);
    // T4 back-to-back frames
    clear_mon(); frame(0, 0); frame(100, 0); idle(2); chk_table("t4", t4, 8, 2);
    // T5 abort at (2,1): 9 pixels, then sof restarts the frame
    clear_mon(); frame(50, 0, 9); frame(0, 0); idle(2); chk_table("t5", t1, 4, 1);
    // T6 async reset right after (3,2) is accepted
    clear_mon(); frame(0, 0, 15);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_reset_window", cur_win(), '0);
    chk("t6_reset_win_valid", win_t'(bus.win_valid_out), '0);
    chk("t6_reset_frame_done", win_t'(bus.frame_done_out), '0);
    model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon(); frame(0, 0); idle(2); chk_table("t6", t1, 4, 1);

    // randomized traffic with sparse sof against the model
    for (int k = 0; k < 800; k++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      step(v, v && (k == 0 || $urandom_range(0, 39) == 0), DW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
